segment_transition_scheduler: RTL and testbench

Sequences segment swaps for one playback datapath (STM or modulation) in the AUTD3 FPGA. It accepts one pending transition request at a time and holds it until its trigger condition fires: immediate, index wrap, system time, or GPIO edge. It then switches the active segment and counts finite repetitions of the new segment, raising STOP when the last repetition ends. It sits between the controller settings path and the stm/modulation blocks, which use SEGMENT to select their memory bank.

---
 rtl/segment_transition_scheduler.sv | 186 ++++++++++++++++++
 tb/tb_segment_transition_scheduler.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/segment_transition_scheduler.sv
// Holds one segment-swap request until its trigger fires (immediate, index wrap, system time, GPIO edge),
// then swaps SEGMENT (1-cycle latency from trigger) and counts finite repeats; REQ_READY low while a request is pending.
module segment_transition_scheduler #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [15:0] REP_INF     = 16'hFFFF
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [63:0] i_sys_time,
  input  logic        i_update,
  input  logic [15:0] i_idx,
  input  logic [15:0] i_cycle,
  input  logic [3:0]  i_gpio_in,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_segment,
  input  logic [2:0]  i_req_mode,
  input  logic [63:0] i_req_value,
  input  logic [15:0] i_req_rep,
  output logic        o_segment,
  output logic        o_swap,
  output logic        o_stop,
  output logic        o_busy,
  output logic        o_err
);

  localparam logic [2:0] MODE_IMMEDIATE = 3'd0;
  localparam logic [2:0] MODE_SYNC_IDX  = 3'd1;
  localparam logic [2:0] MODE_SYS_TIME  = 3'd2;
  localparam logic [2:0] MODE_GPIO      = 3'd3;

  typedef enum logic {S_IDLE, S_PENDING} state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic        r_lat_segment;
  logic [2:0]  r_lat_mode;
  logic [63:0] r_lat_value;
  logic [15:0] r_lat_rep;

  logic        r_segment;
  logic        r_swap;
  logic        r_stop;
  logic        r_err;
  logic [15:0] r_rep_cnt;

  logic [3:0]  r_gpio_sync [SYNC_STAGES];
  logic [3:0]  r_gpio_last;
  logic [3:0]  r_gpio_rise;

  logic        w_wrap;
  logic        w_bad_req;
  logic        w_trig;
  logic        w_accept;
  logic        w_reject;
  logic        w_fire;
  logic        w_fire_segment;
  logic [15:0] w_fire_rep;

  assign w_wrap = i_update && (i_idx == i_cycle);

  always_comb begin
    w_bad_req = 1'b0;
    if (i_req_mode[2])
      w_bad_req = 1'b1;
    else if ((i_req_mode != MODE_IMMEDIATE) && (i_req_segment == r_segment))
      w_bad_req = 1'b1;
    else if ((i_req_mode == MODE_SYS_TIME) && (i_req_value < i_sys_time))
      w_bad_req = 1'b1;
  end

  always_comb begin
    w_trig = 1'b0;
    case (r_lat_mode)
      MODE_SYNC_IDX: w_trig = w_wrap;
      MODE_SYS_TIME: w_trig = (i_sys_time >= r_lat_value);
      MODE_GPIO:     w_trig = r_gpio_rise[r_lat_value[1:0]];
      default:       w_trig = 1'b0;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      r_state <= S_IDLE;
    else
      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt    = r_state;
    o_req_ready    = 1'b0;
    o_busy         = 1'b0;
    w_accept       = 1'b0;
    w_reject       = 1'b0;
    w_fire         = 1'b0;
    w_fire_segment = r_lat_segment;
    w_fire_rep     = r_lat_rep;
    case (r_state)
      S_IDLE: begin
        o_req_ready = 1'b1;
        if (i_req_valid) begin
          if (w_bad_req) begin
            w_reject = 1'b1;
          end else if (i_req_mode == MODE_IMMEDIATE) begin
            // Immediate requests fire straight from IDLE, bypassing PENDING.
            w_fire         = 1'b1;
            w_fire_segment = i_req_segment;
            w_fire_rep     = i_req_rep;
          end else begin
            w_accept    = 1'b1;
            w_state_nxt = S_PENDING;
          end
        end
      end
      S_PENDING: begin
        o_busy = 1'b1;
        if (w_trig) begin
          w_fire      = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_lat_segment <= 1'b0;
      r_lat_mode    <= MODE_IMMEDIATE;
      r_lat_value   <= '0;
      r_lat_rep     <= REP_INF;
    end else if (w_accept) begin
      r_lat_segment <= i_req_segment;
      r_lat_mode    <= i_req_mode;
      r_lat_value   <= i_req_value;
      r_lat_rep     <= i_req_rep;
    end
  end

  // A fire coinciding with a wrap reloads the counter; that wrap belongs to the old segment.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_segment <= 1'b0;
      r_swap    <= 1'b0;
      r_stop    <= 1'b0;
      r_err     <= 1'b0;
      r_rep_cnt <= REP_INF;
    end else begin
      r_swap <= w_fire;
      r_err  <= w_reject;
      if (w_fire) begin
        r_segment <= w_fire_segment;
        r_rep_cnt <= w_fire_rep;
        r_stop    <= 1'b0;
      end else if (w_wrap && !r_stop && (r_rep_cnt != REP_INF)) begin
        if (r_rep_cnt == 16'd0)
          r_stop <= 1'b1;
        else
          r_rep_cnt <= r_rep_cnt - 16'd1;
      end
    end
  end

  // Rise pulse is registered so it lines up as a single-cycle trigger for PENDING only.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++)
        r_gpio_sync[i] <= 4'd0;
      r_gpio_last <= 4'd0;
      r_gpio_rise <= 4'd0;
    end else begin
      r_gpio_sync[0] <= i_gpio_in;
      for (int i = 1; i < SYNC_STAGES; i++)
        r_gpio_sync[i] <= r_gpio_sync[i-1];
      r_gpio_last <= r_gpio_sync[SYNC_STAGES-1];
      r_gpio_rise <= r_gpio_sync[SYNC_STAGES-1] & ~r_gpio_last;
    end
  end

  assign o_segment = r_segment;
  assign o_swap    = r_swap;
  assign o_stop    = r_stop;
  assign o_err     = r_err;

endmodule

// File: tb/tb_segment_transition_scheduler.sv
// Directed bench for segment_transition_scheduler: reset, each trigger mode, finite looping, rejects, mid-pending reset.
module tb_segment_transition_scheduler;

  localparam logic [15:0] REP_INF = 16'hFFFF;

  logic        clk;
  logic        rst_n;
  logic [63:0] sys_time;
  logic        update;
  logic [15:0] idx;
  logic [15:0] cyc;
  logic [3:0]  gpio;
  logic        req_valid;
  logic        req_ready;
  logic        req_segment;
  logic [2:0]  req_mode;
  logic [63:0] req_value;
  logic [15:0] req_rep;
  logic        segment;
  logic        swap;
  logic        stop;
  logic        busy;
  logic        err;

  int n_tests;
  int n_fail;
  int cnt;
  logic [63:0] target;

  segment_transition_scheduler #(.SYNC_STAGES(2), .REP_INF(REP_INF)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_sys_time(sys_time), .i_update(update),
    .i_idx(idx), .i_cycle(cyc), .i_gpio_in(gpio), .i_req_valid(req_valid),
    .o_req_ready(req_ready), .i_req_segment(req_segment), .i_req_mode(req_mode),
    .i_req_value(req_value), .i_req_rep(req_rep), .o_segment(segment),
    .o_swap(swap), .o_stop(stop), .o_busy(busy), .o_err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
    sys_time = sys_time + 64'd1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic request(input logic seg, input logic [2:0] mode, input logic [63:0] val, input logic [15:0] rep);
    req_valid   = 1'b1;
    req_segment = seg;
    req_mode    = mode;
    req_value   = val;
    req_rep     = rep;
    step();
    req_valid   = 1'b0;
  endtask

  initial begin
    n_tests = 0; n_fail = 0;
    rst_n = 1'b0; sys_time = 64'd1000; update = 1'b0; idx = 16'd0; cyc = 16'd9;
    gpio = 4'd0; req_valid = 1'b0; req_segment = 1'b0; req_mode = 3'd0;
    req_value = 64'd0; req_rep = REP_INF;
    repeat (3) step();
    check("rst_segment", segment, 0);
    check("rst_swap", swap, 0);
    check("rst_stop", stop, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    check("rst_ready", req_ready, 1);
    rst_n = 1'b1;
    step();

    // IMMEDIATE to segment 1, infinite
    request(1'b1, 3'd0, 64'd0, REP_INF);
    check("imm_swap", swap, 1);
    check("imm_segment", segment, 1);
    check("imm_err", err, 0);
    check("imm_ready", req_ready, 1);
    step();
    check("imm_swap_pulse", swap, 0);

    // SYNC_IDX to segment 0, CYCLE=9, UPDATE every 4 cycles
    request(1'b0, 3'd1, 64'd0, REP_INF);
    check("sidx_busy", busy, 1);
    check("sidx_ready_low", req_ready, 0);
    cnt = 0;
    for (int k = 0; k <= 9; k++) begin
      update = 1'b1; idx = 16'(k);
      step();
      update = 1'b0;
      if (k < 9) begin
        if (swap || !busy) cnt++;
        repeat (3) begin
          step();
          if (swap || !busy) cnt++;
        end
      end
    end
    check("sidx_no_early_swap", cnt, 0);
    check("sidx_swap", swap, 1);
    check("sidx_segment", segment, 0);
    check("sidx_busy_clear", busy, 0);
    check("sidx_ready_back", req_ready, 1);
    step();

    // SYS_TIME to segment 1 at now+100
    target = sys_time + 64'd100;
    request(1'b1, 3'd2, target, REP_INF);
    cnt = 0;
    if (swap) cnt++;
    repeat (99) begin
      step();
      if (swap) cnt++;
    end
    check("st_no_early_swap", cnt, 0);
    check("st_busy", busy, 1);
    step();
    check("st_swap", swap, 1);
    check("st_segment", segment, 1);

    // SYS_TIME in the past is rejected
    request(1'b0, 3'd2, sys_time - 64'd1, REP_INF);
    check("st_err", err, 1);
    check("st_err_segment", segment, 1);
    check("st_err_busy", busy, 0);
    check("st_err_ready", req_ready, 1);
    step();
    check("st_err_pulse", err, 0);

    // GPIO pin 2: edge before PENDING is forgotten, other pins and falling edge ignored
    gpio = 4'b0100;
    repeat (6) step();
    request(1'b0, 3'd3, 64'd2, REP_INF);
    check("gpio_busy", busy, 1);
    cnt = 0;
    gpio = 4'b1111;
    repeat (6) begin step(); if (swap) cnt++; end
    gpio = 4'b0100;
    repeat (6) begin step(); if (swap) cnt++; end
    gpio = 4'b0000;
    repeat (6) begin step(); if (swap) cnt++; end
    check("gpio_no_false_swap", cnt, 0);
    check("gpio_still_busy", busy, 1);
    gpio = 4'b0100;
    cnt = 0;
    repeat (3) begin step(); if (swap) cnt++; end
    check("gpio_no_early_swap", cnt, 0);
    step();
    check("gpio_swap", swap, 1);
    check("gpio_segment", segment, 0);
    gpio = 4'b0000;
    step();

    // Finite loop REP=2, CYCLE=3, wrap coincident with the swap is not counted
    cyc = 16'd3;
    update = 1'b1; idx = 16'd3;
    request(1'b1, 3'd0, 64'd0, 16'd2);
    update = 1'b0;
    check("loop_swap", swap, 1);
    check("loop_stop0", stop, 0);
    for (int w = 0; w < 3; w++) begin
      step();
      update = 1'b1; idx = 16'd3;
      step();
      update = 1'b0;
      check($sformatf("loop_wrap%0d", w), stop, (w == 2) ? 64'd1 : 64'd0);
    end
    update = 1'b1; idx = 16'd3;
    step();
    update = 1'b0;
    check("loop_stop_hold", stop, 1);
    request(1'b0, 3'd0, 64'd0, 16'd0);
    check("loop_reload_swap", swap, 1);
    check("loop_reload_stop", stop, 0);
    update = 1'b1; idx = 16'd3;
    step();
    update = 1'b0;
    check("loop_play_once", stop, 1);

    // Errors
    request(1'b1, 3'd5, 64'd0, REP_INF);
    check("mode5_err", err, 1);
    check("mode5_segment", segment, 0);
    check("mode5_ready", req_ready, 1);
    step();
    request(1'b0, 3'd1, 64'd0, REP_INF);
    check("same_seg_err", err, 1);
    check("same_seg_busy", busy, 0);
    step();

    // Reset while PENDING
    request(1'b1, 3'd0, 64'd0, REP_INF);
    check("pre_rst_segment", segment, 1);
    request(1'b0, 3'd1, 64'd0, REP_INF);
    check("pre_rst_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_segment", segment, 0);
    check("arst_ready", req_ready, 1);
    step();
    rst_n = 1'b1;
    cnt = 0;
    repeat (4) begin
      update = 1'b1; idx = 16'd3;
      step();
      if (swap || busy) cnt++;
    end
    update = 1'b0;
    check("arst_no_swap", cnt, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
